// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and per-register outstanding-write scoreboard for a 16x32 register file.
// Optional feature: define WB_RR_ARB_EN for round-robin arbitration (default build uses fixed B priority).
module regfile_wb_arbiter #(
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_rd,
    input  logic [DATA_W-1:0]    a_wd,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_rd,
    input  logic [DATA_W-1:0]    b_wd,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_rd,
    output logic [DATA_W-1:0]    rf_wd,
    output logic [REG_COUNT-1:0] busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                 grant_a_s;
    logic                 grant_b_s;
    logic                 xfer_s;
    logic [ADDR_W-1:0]    xfer_rd_s;
    logic [DATA_W-1:0]    xfer_wd_s;
    logic [REG_COUNT-1:0] inc_s;
    logic [REG_COUNT-1:0] dec_s;
    logic [CNT_W-1:0]     cnt_r [REG_COUNT];

`ifdef WB_RR_ARB_EN
    // last_grant_r: 1 means B won the most recent transfer, so A is favoured next
    logic last_grant_r;

    // Round-robin grant under contention, otherwise grant the sole requester
    always_comb begin
        if (a_valid && b_valid) begin
            grant_a_s = last_grant_r;
            grant_b_s = !last_grant_r;
        end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
        end
    end

    // Remember which port won the last completed transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (xfer_s) begin
            last_grant_r <= grant_b_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: the load unit always wins under contention
    always_comb begin
        grant_a_s = a_valid && !b_valid;
        grant_b_s = b_valid;
    end
`endif

    // Handshake outputs are suppressed while reset is asserted
    always_comb begin
        a_ready   = grant_a_s && rst_n;
        b_ready   = grant_b_s && rst_n;
        xfer_s    = a_ready || b_ready;
        iss_ready = rst_n && (cnt_r[iss_rd] != CNT_MAX);
        if (grant_b_s) begin
            xfer_rd_s = b_rd;
            xfer_wd_s = b_wd;
        end else begin
            xfer_rd_s = a_rd;
            xfer_wd_s = a_wd;
        end
    end

    // Registered write port; writes to x0 are consumed without asserting rf_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rd <= {ADDR_W{1'b0}};
            rf_wd <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            rf_we <= (xfer_rd_s != {ADDR_W{1'b0}});
            rf_rd <= xfer_rd_s;
            rf_wd <= xfer_wd_s;
        end else begin
            rf_we <= 1'b0;
            rf_rd <= rf_rd;
            rf_wd <= rf_wd;
        end
    end

    // Per-register increment/decrement requests and busy flags
    always_comb begin
        inc_s = {REG_COUNT{1'b0}};
        dec_s = {REG_COUNT{1'b0}};
        busy  = {REG_COUNT{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            inc_s[i] = iss_valid && iss_ready && (iss_rd == ADDR_W'(i));
            dec_s[i] = rf_we && (rf_rd == ADDR_W'(i));
            busy[i]  = (cnt_r[i] != CNT_ZERO);
        end
    end

    // Outstanding-write counters; x0 is pinned to zero, decrement floors at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (i == 0) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (inc_s[i] && !dec_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end else if (dec_s[i] && !inc_s[i] && (cnt_r[i] != CNT_ZERO)) begin
                    cnt_r[i] <= cnt_r[i] - CNT_ONE;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

endmodule
